// File: rtl/pwm_frame_gen.sv
// pwm_frame_gen: frame-based PWM source driving V_PWM_C.
// Period/duty are staged on load and move to the active registers only at a
// frame boundary, so a running frame is never cut short or glitched.
module pwm_frame_gen #(
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned PERIOD_RST = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [CNT_W-1:0] period,
  input  logic [CNT_W-1:0] duty,
  input  logic             load,
  output logic             load_ack,
  output logic             V_PWM_C,
  output logic             frame_start
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] STOP = 2'd2;

  logic [1:0]       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
  logic [CNT_W-1:0] period_a, duty_a, period_s, duty_s;
  logic [CNT_W-1:0] period_n, duty_n;
  logic             pend, xfer, wrap, boundary;
  logic             v_n, fs_n;

  // Frame wrap detection and boundary transfer of staged/bypassed settings.
  // A load on the boundary edge itself wins over older staged values.
  always_comb begin
    wrap     = (cnt == period_a);
    cnt_inc  = wrap ? '0 : cnt + 1'b1;
    boundary = (state == IDLE) || wrap;
    period_n = period_a;
    duty_n   = duty_a;
    xfer     = 1'b0;
    if (boundary) begin
      if (load) begin
        period_n = period;
        duty_n   = duty;
        xfer     = 1'b1;
      end else if (pend) begin
        period_n = period_s;
        duty_n   = duty_s;
        xfer     = 1'b1;
      end
    end
  end

  // Next state and next outputs; the output compares against the counter's
  // next value so the first high clock lines up with frame_start.
  always_comb begin
    state_n = state;
    cnt_n   = '0;
    v_n     = 1'b0;
    fs_n    = 1'b0;
    case (state)
      IDLE: begin
        if (en) begin
          state_n = RUN;
          fs_n    = 1'b1;
          v_n     = (duty_n != '0);
        end
      end
      default: begin
        if (state == STOP && !en && wrap) begin
          state_n = IDLE;  // graceful stop: current frame has completed
        end else begin
          state_n = en ? RUN : STOP;
          cnt_n   = cnt_inc;
          v_n     = (cnt_inc < duty_n);
          fs_n    = (cnt_inc == '0);
        end
      end
    endcase
  end

  // Register state, counter, settings and outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      period_a    <= CNT_W'(PERIOD_RST);
      duty_a      <= '0;
      period_s    <= '0;
      duty_s      <= '0;
      pend        <= 1'b0;
      load_ack    <= 1'b0;
      V_PWM_C     <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      period_a    <= period_n;
      duty_a      <= duty_n;
      load_ack    <= xfer;
      V_PWM_C     <= v_n;
      frame_start <= fs_n;
      if (boundary) begin
        pend <= 1'b0;
      end else if (load) begin
        period_s <= period;
        duty_s   <= duty;
        pend     <= 1'b1;
      end
    end
  end

endmodule
